// File: rtl/minmax_pkg.sv
// Shared constants and FSM state encoding for the signed burst min/max tracker.
package minmax_pkg;

    localparam int N_DEF     = 32;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_ACCEPT,
        S_CMP_MIN,
        S_CMP_MAX,
        S_DONE
    } state_t;

endpackage

// File: rtl/slt.sv
// Signed strict less-than comparator; the single magnitude compare shared by the tracker.
module slt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    assign lt = $signed(a) < $signed(b);

endmodule

// File: rtl/signed_minmax_seq.sv
// Sequential signed min/max over a burst of len samples using one time-shared comparator.
// Optional MINMAX_INDEX_EN adds min_idx/max_idx positions of the retained extremes.
//
// state     | meaning
// S_IDLE    | waiting for start; len captured with start
// S_FIRST   | accept first sample, seeds min_out/max_out
// S_ACCEPT  | wait for next sample, latch into sample register
// S_CMP_MIN | comparator: sample < min_out
// S_CMP_MAX | comparator: max_out < sample, count sample done
// S_DONE    | one-cycle done pulse
module signed_minmax_seq
    import minmax_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     min_out,
    output logic [N-1:0]     max_out
`ifdef MINMAX_INDEX_EN
    ,
    output logic [CNT_W-1:0] min_idx,
    output logic [CNT_W-1:0] max_idx
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [N-1:0]     sample;
    logic [N-1:0]     cmp_a;
    logic [N-1:0]     cmp_b;
    logic             cmp_lt;
    logic             last;

    assign last = (remaining == CNT_W'(1));

    slt #(.N(N)) u_slt (
        .a  (cmp_a),
        .b  (cmp_b),
        .lt (cmp_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        cmp_a     = max_out;
        cmp_b     = sample;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (len == '0) ? S_DONE : S_FIRST;
            end
            S_FIRST: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = last ? S_DONE : S_ACCEPT;
            end
            S_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_CMP_MIN;
            end
            S_CMP_MIN: begin
                cmp_a     = sample;
                cmp_b     = min_out;
                state_nxt = S_CMP_MAX;
            end
            S_CMP_MAX: begin
                state_nxt = last ? S_DONE : S_ACCEPT;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            sample    <= '0;
            min_out   <= '0;
            max_out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= len;
                        if (len == '0) begin
                            min_out <= '0;
                            max_out <= '0;
                        end
                    end
                end
                S_FIRST: begin
                    if (in_valid) begin
                        min_out   <= in_data;
                        max_out   <= in_data;
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) sample <= in_data;
                end
                S_CMP_MIN: begin
                    if (cmp_lt) min_out <= sample;
                end
                S_CMP_MAX: begin
                    if (cmp_lt) max_out <= sample;
                    remaining <= remaining - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef MINMAX_INDEX_EN
    // pos is the burst position of the value currently held in sample
    logic [CNT_W-1:0] pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= '0;
            min_idx <= '0;
            max_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && len == '0) begin
                        min_idx <= '0;
                        max_idx <= '0;
                    end
                end
                S_FIRST: begin
                    if (in_valid) begin
                        pos     <= '0;
                        min_idx <= '0;
                        max_idx <= '0;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) pos <= pos + CNT_W'(1);
                end
                S_CMP_MIN: begin
                    if (cmp_lt) min_idx <= pos;
                end
                S_CMP_MAX: begin
                    if (cmp_lt) max_idx <= pos;
                end
                default: ;
            endcase
        end
    end
`else
    // no position tracking in this build
`endif

endmodule

// File: tb/tb_signed_minmax_seq.sv
// Randomized scoreboard bench for signed_minmax_seq; honours MINMAX_INDEX_EN when defined.
module tb_signed_minmax_seq;

    localparam int N     = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [N-1:0]     min_out;
    logic [N-1:0]     max_out;
`ifdef MINMAX_INDEX_EN
    logic [CNT_W-1:0] min_idx;
    logic [CNT_W-1:0] max_idx;
`endif

    typedef struct packed {
        logic [N-1:0]     mn;
        logic [N-1:0]     mx;
        logic [CNT_W-1:0] mi;
        logic [CNT_W-1:0] xi;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] stim_q[$];
    int           checks   = 0;
    int           failures = 0;

    signed_minmax_seq #(.N(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .min_out  (min_out),
        .max_out  (max_out)
`ifdef MINMAX_INDEX_EN
        ,
        .min_idx  (min_idx),
        .max_idx  (max_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Reference: first sample seeds, later samples replace only when strictly beyond.
    function automatic exp_t model(input int n);
        exp_t e;
        e = '0;
        if (n == 0) return e;
        e.mn = stim_q[0];
        e.mx = stim_q[0];
        for (int i = 1; i < n; i++) begin
            if ($signed(stim_q[i]) < $signed(e.mn)) begin
                e.mn = stim_q[i];
                e.mi = CNT_W'(i);
            end
            if ($signed(stim_q[i]) > $signed(e.mx)) begin
                e.mx = stim_q[i];
                e.xi = CNT_W'(i);
            end
        end
        return e;
    endfunction

    // Monitor: every done pulse consumes one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    e = exp_q.pop_front();
                    check("min_out", 64'(min_out), 64'(e.mn));
                    check("max_out", 64'(max_out), 64'(e.mx));
`ifdef MINMAX_INDEX_EN
                    check("min_idx", 64'(min_idx), 64'(e.mi));
                    check("max_idx", 64'(max_idx), 64'(e.xi));
`endif
                end
            end
        end
    end

    // Runs one burst from stim_q; called and returning at a negedge.
    task automatic run_burst(input int n, input int gap_idx, input int gap_len, input bit pulse);
        int cyc;
        cyc = 0;
        while (busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) check("idle_timeout", 64'(busy), 64'd0);
        start = 1'b1;
        len   = CNT_W'(n);
        exp_q.push_back(model(n));
        @(negedge clk);
        start = 1'b0;
        len   = CNT_W'($urandom);
        if (n == 0) begin
            check("len0_done_next", 64'(done), 64'd1);
            check("len0_no_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
            check("len0_idle_ready", 64'(in_ready), 64'd0);
            check("len0_idle_busy", 64'(busy), 64'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i == gap_idx) begin
                in_valid = 1'b0;
                cyc = 0;
                while (!in_ready && cyc < 20) begin
                    @(negedge clk);
                    cyc++;
                end
                for (int g = 0; g < gap_len; g++) begin
                    check("gap_ready", 64'(in_ready), 64'd1);
                    if (pulse && g == 1) begin
                        start = 1'b1;
                        len   = '0;
                    end else begin
                        start = 1'b0;
                    end
                    @(negedge clk);
                end
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = stim_q[i];
            cyc = 0;
            while (!in_ready && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 20) check("ready_timeout", 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = N'($urandom);
        end
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("done_latency", 64'(cyc), (n == 1) ? 64'd1 : 64'd3);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int pick;
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_min", 64'(min_out), 64'd0);
        check("rst_max", 64'(max_out), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        stim_q = '{32'd5, 32'hFFFF_FFFD, 32'd12, 32'hFFFF_FFFD};
        run_burst(4, -1, 0, 1'b0);

        stim_q = '{32'h8000_0000, 32'h7FFF_FFFF};
        run_burst(2, -1, 0, 1'b0);

        stim_q.delete();
        run_burst(0, -1, 0, 1'b0);

        stim_q = '{32'd3, 32'hFFFF_FFF6, 32'd40};
        run_burst(3, 1, 5, 1'b1);

        // Reset while the second sample sits in CMP_MIN; no result expected for it.
        stim_q = '{32'd9, 32'hFFFF_FFFC, 32'd20, 32'd1};
        start = 1'b1;
        len   = CNT_W'(4);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = stim_q[0];
        @(negedge clk);
        in_data  = stim_q[1];
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_min", 64'(min_out), 64'd9);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_min", 64'(min_out), 64'd0);
        check("midrst_max", 64'(max_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        stim_q = '{32'd7};
        run_burst(1, -1, 0, 1'b0);

        stim_q = '{32'hFFFF_FFFF};
        run_burst(1, -1, 0, 1'b0);

        for (int b = 0; b < 30; b++) begin
            n = $urandom_range(0, 8);
            stim_q.delete();
            for (int i = 0; i < n; i++) begin
                pick = $urandom_range(0, 9);
                case (pick)
                    0: stim_q.push_back(32'h8000_0000);
                    1: stim_q.push_back(32'h7FFF_FFFF);
                    2: stim_q.push_back(32'hFFFF_FFFF);
                    3: stim_q.push_back((i > 0) ? stim_q[$urandom_range(0, i - 1)] : 32'd0);
                    4: stim_q.push_back(N'($urandom_range(0, 15)) - N'(8));
                    default: stim_q.push_back(N'($urandom));
                endcase
            end
            run_burst(n, (n > 1 && $urandom_range(0, 2) == 0) ? 1 : -1,
                      $urandom_range(1, 4), 1'(($urandom_range(0, 1))));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
